// File: rtl/ihex_loader.sv
// ROM image loader: raw binary or Intel HEX from the HPS download channel into a
// byte-wide program memory write port, with checksum, range and syntax checking.
module ihex_loader #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned IOCTL_AW  = 25,
    parameter int unsigned BIN_INDEX = 0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_data,
    output logic                busy,
    output logic                done,
    output logic                err_csum,
    output logic                err_syntax,
    output logic                err_range,
    output logic [15:0]         rec_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_TYPE,
        S_DATA,
        S_CSUM
    } state_t;

    state_t              r_state;
    logic                r_dl_prev;
    logic [1:0]          r_dig;
    logic [3:0]          r_hi;
    logic [7:0]          r_sum;
    logic [7:0]          r_len;
    logic [7:0]          r_len_rec;
    logic [15:0]         r_offset;
    logic [2:0]          r_type;
    logic [7:0]          r_idx;
    logic [15:0]         r_data16;
    logic [31:0]         r_base;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_data;
    logic                r_done;
    logic                r_err_csum;
    logic                r_err_syntax;
    logic                r_err_range;
    logic [15:0]         r_rec_count;

    logic                w_nib_ok;
    logic [3:0]          w_nib;
    logic [7:0]          w_byte;
    logic [7:0]          w_sum_next;
    logic [15:0]         w_wr_ptr;
    logic [31:0]         w_wr_addr;
    logic                w_wr_oor;
    logic                w_bin;
    logic                w_bin_oor;
    logic                w_dl_rise;
    logic                w_hex_wr;

    // ASCII hex digit decode, case-insensitive
    always_comb begin
        w_nib_ok = 1'b1;
        w_nib    = 4'd0;
        if (ioctl_dout >= 8'h30 && ioctl_dout <= 8'h39) begin
            w_nib = 4'(ioctl_dout - 8'h30);
        end else if (ioctl_dout >= 8'h41 && ioctl_dout <= 8'h46) begin
            w_nib = 4'(ioctl_dout - 8'h37);
        end else if (ioctl_dout >= 8'h61 && ioctl_dout <= 8'h66) begin
            w_nib = 4'(ioctl_dout - 8'h57);
        end else begin
            w_nib_ok = 1'b0;
        end
    end

    assign w_byte     = {r_hi, w_nib};
    assign w_sum_next = r_sum + w_byte;
    // Record offset plus byte index wraps at 16 bits before the base is added
    assign w_wr_ptr   = r_offset + 16'(r_idx);
    assign w_wr_addr  = r_base + 32'(w_wr_ptr);
    assign w_wr_oor   = (w_wr_addr >> ADDR_W) != 32'd0;
    assign w_bin      = (ioctl_index == 8'(BIN_INDEX));
    assign w_bin_oor  = (ioctl_addr >> ADDR_W) != '0;
    assign w_dl_rise  = ioctl_download & ~r_dl_prev;
    assign w_hex_wr   = ioctl_download & ioctl_wr & ~w_bin;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dl_prev    <= 1'b0;
            r_dig        <= 2'd0;
            r_hi         <= 4'd0;
            r_sum        <= 8'd0;
            r_len        <= 8'd0;
            r_len_rec    <= 8'd0;
            r_offset     <= 16'd0;
            r_type       <= 3'd0;
            r_idx        <= 8'd0;
            r_data16     <= 16'd0;
            r_base       <= 32'd0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= 8'd0;
            r_done       <= 1'b0;
            r_err_csum   <= 1'b0;
            r_err_syntax <= 1'b0;
            r_err_range  <= 1'b0;
            r_rec_count  <= 16'd0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_mem_wr  <= 1'b0;

            // Clears come first so a byte arriving on the same edge still takes effect
            if (w_dl_rise) begin
                r_done       <= 1'b0;
                r_err_csum   <= 1'b0;
                r_err_syntax <= 1'b0;
                r_err_range  <= 1'b0;
                r_rec_count  <= 16'd0;
                r_base       <= 32'd0;
            end

            if (!ioctl_download || w_bin) begin
                r_state <= S_IDLE;
            end

            if (ioctl_download && ioctl_wr && w_bin) begin
                if (w_bin_oor) begin
                    r_err_range <= 1'b1;
                end else begin
                    r_mem_wr   <= 1'b1;
                    r_mem_addr <= ioctl_addr[ADDR_W-1:0];
                    r_mem_data <= ioctl_dout;
                end
            end

            if (w_hex_wr) begin
                if (r_state == S_IDLE) begin
                    if (ioctl_dout == 8'h3A) begin
                        r_state <= S_LEN;
                        r_sum   <= 8'd0;
                        r_dig   <= 2'd0;
                    end
                end else if (!w_nib_ok) begin
                    r_err_syntax <= 1'b1;
                    r_state      <= S_IDLE;
                end else begin
                    r_hi  <= w_nib;
                    r_dig <= r_dig + 2'd1;
                    if (r_dig[0]) begin
                        r_sum <= w_sum_next;
                    end
                    case (r_state)
                        S_LEN: begin
                            if (r_dig[0]) begin
                                r_len     <= w_byte;
                                r_len_rec <= w_byte;
                                r_dig     <= 2'd0;
                                r_state   <= S_ADDR;
                            end
                        end
                        S_ADDR: begin
                            if (r_dig[0]) begin
                                r_offset <= {r_offset[7:0], w_byte};
                                if (r_dig == 2'd3) begin
                                    r_dig   <= 2'd0;
                                    r_state <= S_TYPE;
                                end
                            end
                        end
                        S_TYPE: begin
                            if (r_dig[0]) begin
                                r_dig <= 2'd0;
                                r_idx <= 8'd0;
                                if (w_byte > 8'd5) begin
                                    r_err_syntax <= 1'b1;
                                    r_state      <= S_IDLE;
                                end else begin
                                    r_type  <= w_byte[2:0];
                                    r_state <= (r_len == 8'd0) ? S_CSUM : S_DATA;
                                end
                            end
                        end
                        S_DATA: begin
                            if (r_dig[0]) begin
                                r_dig    <= 2'd0;
                                r_data16 <= {r_data16[7:0], w_byte};
                                r_idx    <= r_idx + 8'd1;
                                r_len    <= r_len - 8'd1;
                                if (r_len == 8'd1) begin
                                    r_state <= S_CSUM;
                                end
                                if (r_type == 3'd0) begin
                                    if (w_wr_oor) begin
                                        r_err_range <= 1'b1;
                                    end else begin
                                        r_mem_wr   <= 1'b1;
                                        r_mem_addr <= w_wr_addr[ADDR_W-1:0];
                                        r_mem_data <= w_byte;
                                    end
                                end
                            end
                        end
                        S_CSUM: begin
                            if (r_dig[0]) begin
                                r_state <= S_IDLE;
                                if (w_sum_next == 8'd0) begin
                                    r_rec_count <= r_rec_count + 16'd1;
                                    case (r_type)
                                        3'd1: r_done <= 1'b1;
                                        3'd2: begin
                                            if (r_len_rec == 8'd2) r_base <= 32'(r_data16) << 4;
                                            else                   r_err_syntax <= 1'b1;
                                        end
                                        3'd4: begin
                                            if (r_len_rec == 8'd2) r_base <= {r_data16, 16'd0};
                                            else                   r_err_syntax <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end else begin
                                    r_err_csum <= 1'b1;
                                end
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err_csum   = r_err_csum;
    assign err_syntax = r_err_syntax;
    assign err_range  = r_err_range;
    assign rec_count  = r_rec_count;

endmodule
